// File: rtl/wb_write_arbiter.sv
`default_nettype none
// =============================================================================
// wb_write_arbiter
//   Merges ALU and buffered LSU/multiplier writebacks into one RF write port.
//   Revision: 1.0
// =============================================================================
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_rd,
  input  logic [31:0]             alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [4:0]              lsu_rd,
  input  logic [31:0]             lsu_data,
  output logic                    rf_we,
  output logic [4:0]              rf_rd,
  output logic [31:0]             rf_wdata,
  output logic [31:0]             pending,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   C_DEPTH      = (AW + 1)'(DEPTH);

  logic [4:0]       mem_rd_q   [DEPTH];
  logic [4:0]       mem_rd_d   [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [31:0]      mem_data_d [DEPTH];
  logic [DEPTH-1:0] valid_q,   valid_d;
  logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [AW:0]      count_q,   count_d;
  logic [SW-1:0]    starve_q,  starve_d;
  logic             rf_we_q,   rf_we_d;
  logic [4:0]       rf_rd_q,   rf_rd_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             hazard;
  logic             force_drain;
  logic             alu_grant;
  logic             fifo_grant;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic [31:0]      pending_w;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == C_DEPTH);
  assign push        = lsu_valid && !fifo_full;
  assign head_rd     = mem_rd_q[rd_ptr_q];
  assign head_data   = mem_data_q[rd_ptr_q];

  // Occupancy-derived mask; an entry leaving on this edge is still visible now.
  always_comb begin
    pending_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pending_w[mem_rd_q[i]] = 1'b1;
      end
    end
    pending_w[0] = 1'b0;
  end

  assign hazard      = alu_valid && (alu_rd != 5'd0) && pending_w[alu_rd];
  assign force_drain = (starve_q >= C_STARVE_MAX) && !fifo_empty;
  assign alu_grant   = alu_valid && !hazard && !force_drain;
  assign fifo_grant  = !alu_grant && !fifo_empty;

  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (fifo_grant) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_rd_d[wr_ptr_q]   = lsu_rd;
      mem_data_d[wr_ptr_q] = lsu_data;
      valid_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    case ({push, fifo_grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_grant) begin
      starve_d = '0;
    end else if (alu_grant && (starve_q != C_STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Address and data hold while idle so the port only toggles on real writes.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_grant) begin
      rf_we_d    = (alu_rd != 5'd0);
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
    end else if (fifo_grant) begin
      rf_we_d    = (head_rd != 5'd0);
      rf_rd_d    = head_rd;
      rf_wdata_d = head_data;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign alu_ready  = !hazard && !force_drain;
  assign lsu_ready  = !fifo_full;
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign pending    = pending_w;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// =============================================================================
// tb_wb_write_arbiter
//   Table vectors, directed corner sequences and random traffic vs a queue model.
//   Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_wb_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [4:0]    alu_rd = '0;
  logic [31:0]   alu_data = '0;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [4:0]    lsu_rd = '0;
  logic [31:0]   lsu_data = '0;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wdata;
  logic [31:0]   pending;
  logic [CW-1:0] fifo_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: an in-order queue plus the starvation rule.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_rd     = 5'd0;
    m_wdata  = 32'd0;
  endtask

  task automatic model_cycle(input string tag);
    logic [31:0] pend;
    bit          haz, frc, aready, lready;
    ent_t        e;
    pend = '0;
    foreach (mq[k]) if (mq[k].rd != 5'd0) pend[mq[k].rd] = 1'b1;
    lready = (mq.size() < DEPTH);
    haz    = alu_valid && (alu_rd != 5'd0) && pend[alu_rd];
    frc    = (m_starve >= STARVE_LIMIT) && (mq.size() > 0);
    aready = !haz && !frc;
    cmp({tag, ".alu_ready"}, 32'(alu_ready), 32'(aready));
    cmp({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(lready));
    cmp({tag, ".pending"},   pending, pend);
    cmp({tag, ".count"},     32'(fifo_count), 32'(mq.size()));
    cmp({tag, ".rf_we"},     32'(rf_we), 32'(m_we));
    cmp({tag, ".rf_rd"},     32'(rf_rd), 32'(m_rd));
    cmp({tag, ".rf_wdata"},  rf_wdata, m_wdata);
    if (alu_valid && aready) begin
      m_we    = (alu_rd != 5'd0);
      m_rd    = alu_rd;
      m_wdata = alu_data;
      if (mq.size() == 0)             m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
    end else if (mq.size() > 0) begin
      e        = mq.pop_front();
      m_we     = (e.rd != 5'd0);
      m_rd     = e.rd;
      m_wdata  = e.data;
      m_starve = 0;
    end else begin
      m_we     = 1'b0;
      m_starve = 0;
    end
    if (lsu_valid && lready) mq.push_back('{rd: lsu_rd, data: lsu_data});
  endtask

  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input string tag);
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    model_cycle(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "idle");
  endtask

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adata;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldata;
    logic        xa;  logic xl; logic xw;
    logic [4:0]  xrd; logic [31:0] xwd; int xc; logic [31:0] xp;
  } vec_t;

  vec_t vt[$];

  function automatic void row(input bit av, input int ard, input logic [31:0] ad,
                              input bit lv, input int lrd, input logic [31:0] ld,
                              input bit xa, input bit xl, input bit xw, input int xrd,
                              input logic [31:0] xwd, input int xc, input logic [31:0] xp);
    vec_t v;
    v.av = av; v.ard = 5'(ard); v.adata = ad;
    v.lv = lv; v.lrd = 5'(lrd); v.ldata = ld;
    v.xa = xa; v.xl = xl; v.xw = xw; v.xrd = 5'(xrd); v.xwd = xwd; v.xc = xc; v.xp = xp;
    vt.push_back(v);
  endfunction

  initial begin
    // ALU path, then fill to full and drain under the starvation limit.
    row(1,  5, 32'hDEADBEEF, 0,  0, 0,     1,1,0,  0, 32'h0,        0, 32'h0);
    row(1,  0, 32'h00001234, 0,  0, 0,     1,1,1,  5, 32'hDEADBEEF, 0, 32'h0);
    row(0,  0, 0,            0,  0, 0,     1,1,0,  0, 32'h1234,     0, 32'h0);
    row(0,  0, 0,            0,  0, 0,     1,1,0,  0, 32'h1234,     0, 32'h0);
    row(1,  1, 32'h101,      1, 20, 'hA0,  1,1,0,  0, 32'h1234,     0, 32'h0);
    row(1,  2, 32'h102,      1, 21, 'hA1,  1,1,1,  1, 32'h101,      1, 32'h0010_0000);
    row(1,  3, 32'h103,      1, 22, 'hA2,  1,1,1,  2, 32'h102,      2, 32'h0030_0000);
    row(1,  4, 32'h104,      1, 23, 'hA3,  1,1,1,  3, 32'h103,      3, 32'h0070_0000);
    row(1,  5, 32'h105,      1, 24, 'hA4,  0,0,1,  4, 32'h104,      4, 32'h00F0_0000);
    row(1,  5, 32'h105,      0,  0, 0,     1,1,1, 20, 32'hA0,       3, 32'h00E0_0000);
    row(1,  6, 32'h106,      0,  0, 0,     1,1,1,  5, 32'h105,      3, 32'h00E0_0000);
    row(1,  7, 32'h107,      0,  0, 0,     1,1,1,  6, 32'h106,      3, 32'h00E0_0000);
    row(1,  8, 32'h108,      0,  0, 0,     0,1,1,  7, 32'h107,      3, 32'h00E0_0000);
    row(1,  8, 32'h108,      0,  0, 0,     1,1,1, 21, 32'hA1,       2, 32'h00C0_0000);
    row(1,  9, 32'h109,      0,  0, 0,     1,1,1,  8, 32'h108,      2, 32'h00C0_0000);
    row(1, 10, 32'h10A,      0,  0, 0,     1,1,1,  9, 32'h109,      2, 32'h00C0_0000);
    row(0,  0, 0,            0,  0, 0,     0,1,1, 10, 32'h10A,      2, 32'h00C0_0000);
    row(0,  0, 0,            0,  0, 0,     1,1,1, 22, 32'hA2,       1, 32'h0080_0000);
    row(0,  0, 0,            0,  0, 0,     1,1,1, 23, 32'hA3,       0, 32'h0);
    row(0,  0, 0,            0,  0, 0,     1,1,0, 23, 32'hA3,       0, 32'h0);

    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      cmp("reset.rf_we", 32'(rf_we), 32'd0);
      cmp("reset.count", 32'(fifo_count), 32'd0);
      cmp("reset.lsu_ready", 32'(lsu_ready), 32'd1);
      cmp("reset.alu_ready", 32'(alu_ready), 32'd1);
    end
    @(negedge clk); reset_n = 1'b1;
    idle(5);

    foreach (vt[i]) begin
      cycle(vt[i].av, vt[i].ard, vt[i].adata, vt[i].lv, vt[i].lrd, vt[i].ldata, "vec_model");
      cmp($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vt[i].xa));
      cmp($sformatf("vec%0d.lsu_ready", i), 32'(lsu_ready), 32'(vt[i].xl));
      cmp($sformatf("vec%0d.rf_we", i),     32'(rf_we), 32'(vt[i].xw));
      cmp($sformatf("vec%0d.rf_rd", i),     32'(rf_rd), 32'(vt[i].xrd));
      cmp($sformatf("vec%0d.rf_wdata", i),  rf_wdata, vt[i].xwd);
      cmp($sformatf("vec%0d.count", i),     32'(fifo_count), 32'(vt[i].xc));
      cmp($sformatf("vec%0d.pending", i),   pending, vt[i].xp);
    end
    idle(2);

    // Hazard: ALU write to x7 must wait behind the buffered LSU write to x7.
    cycle(1, 5'd1, 32'h11, 1, 5'd7, 32'h77, "haz0");
    cycle(1, 5'd2, 32'h22, 0, 5'd0, 32'h0,  "haz1");
    cmp("haz1.pending7", 32'(pending[7]), 32'd1);
    cycle(1, 5'd7, 32'h88, 0, 5'd0, 32'h0,  "haz2");
    cmp("haz2.alu_ready", 32'(alu_ready), 32'd0);
    cmp("haz2.pending7", 32'(pending[7]), 32'd1);
    cycle(1, 5'd7, 32'h88, 0, 5'd0, 32'h0,  "haz3");
    cmp("haz3.alu_ready", 32'(alu_ready), 32'd1);
    cmp("haz3.first_write", {rf_we, rf_rd, rf_wdata[25:0]}, {1'b1, 5'd7, 26'h77});
    cmp("haz3.pending7", 32'(pending[7]), 32'd0);
    cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,   "haz4");
    cmp("haz4.second_write", {rf_we, rf_rd, rf_wdata[25:0]}, {1'b1, 5'd7, 26'h88});
    idle(3);

    // Full FIFO with ALU idle: drain one per cycle while LSU keeps offering.
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(i + 1), 32'h300 + i, 1, 5'(16 + i), 32'hC0 + i, "full_fill");
    for (int i = 0; i < 8; i++) begin
      cycle(0, 5'd0, 32'h0, 1, 5'(24 + i), 32'hD0 + i, "full_pp");
      if (i == 0) begin
        cmp("full.lsu_ready", 32'(lsu_ready), 32'd0);
        cmp("full.count", 32'(fifo_count), 32'd4);
      end
      cmp("full.count_le_depth", 32'(fifo_count <= CW'(DEPTH)), 32'd1);
    end
    idle(6);

    // Reset with three buffered entries: none of them may be written afterwards.
    for (int i = 0; i < 3; i++)
      cycle(1, 5'(i + 1), 32'h500 + i, 1, 5'(11 + i), 32'hB0 + i, "rst_fill");
    cmp("rst.pre_count", 32'(fifo_count), 32'd2);
    @(negedge clk);
    alu_valid = 1'b0; lsu_valid = 1'b0; reset_n = 1'b0;
    #1;
    cmp("rst.rf_we", 32'(rf_we), 32'd0);
    cmp("rst.count", 32'(fifo_count), 32'd0);
    cmp("rst.pending", pending, 32'd0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      cmp("rst.no_stale_write", 32'(rf_we), 32'd0);
    end

    // Random traffic with a narrow rd range to provoke hazards and duplicates.
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 4) != 0, 5'($urandom % 8), $urandom,
            ($urandom % 2) != 0, 5'($urandom % 8), $urandom, "rand");
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
